// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-latched, masked, fixed-priority interrupt injector feeding cd's interrupciones code.
module interrupt_controller #(
  parameter int NSRC = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq,
  input  logic            reti,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_in,
  input  logic            gie_we,
  input  logic            gie_in,
  output logic [2:0]      interrupciones,
  output logic [NSRC-1:0] pending,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, INJECT, SERVICE} state_t;
  state_t          state_q, state_d;
  logic [2:0]      code_q, code_d, sel;
  logic [NSRC-1:0] irq_q, pending_q, pending_d, mask_q, mask_d, elig, clr, edge_w;
  logic            gie_q, gie_d, take;
  assign edge_w = irq & ~irq_q;
  assign elig   = pending_q & mask_q & {NSRC{gie_q}};
  assign take   = (state_q == IDLE) && (|elig);
  // Only the source being injected is cleared; a same-cycle new edge re-sets it.
  assign clr       = (state_q == INJECT) ? NSRC'(1) << (code_q - 3'd1) : '0;
  assign pending_d = (pending_q & ~clr) | edge_w;
  assign mask_d    = mask_we ? mask_in : mask_q;
  assign gie_d     = gie_we ? gie_in : gie_q;
  always_comb begin
    sel = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (elig[i]) sel = 3'(i + 1);
  end
  always_comb begin
    state_d = take ? INJECT :
              (state_q == INJECT) ? SERVICE :
              (state_q == SERVICE && reti) ? IDLE : state_q;
    code_d  = take ? sel : '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      code_q    <= '0;
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      gie_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      irq_q     <= irq;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      gie_q     <= gie_d;
    end
  end
  assign interrupciones = code_q;
  assign pending        = pending_q;
  assign busy           = (state_q != IDLE);
endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Prioritised interrupt controller that feeds the 3-bit `interrupciones` vector of the single-cycle datapath `cd`. Latches rising edges on seven external request lines and masks them individually and globally. Arbitrates by fixed priority and injects the winning source code for exactly one cycle, so the datapath substitutes the matching vector instruction. It then blocks further injection until the control unit signals return-from-interrupt. Sits between the I/O devices and `cd`, alongside the control unit.

## Interface
- `NSRC`, default 7: number of request lines. Fixed at 7 because the code width is 3 bits and code 0 means "none".
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `irq`  in  7  request lines. Bit i maps to code i+1. Bit 0 has the highest priority.
- `reti`  in  1  one-cycle strobe from the control unit when the service routine returns.
- `mask_we`  in  1  load `mask_in` into the mask register.
- `mask_in`  in  7  new mask; 1 = source enabled.
- `gie_we`  in  1  load `gie_in` into the global enable.
- `gie_in`  in  1  new global interrupt enable.
- `interrupciones`  out  3  code presented to `cd`; 0 when no injection is in progress.
- `pending`  out  7  latched request bits, unmasked view.
- `busy`  out  1  high in INJECT and SERVICE.

## Operation
- **Edge detect.** `irq_q` holds the previous-cycle `irq` and resets to 0. `edge = irq & ~irq_q`.
  - A line already high when reset is released is therefore seen as an edge on the first clock.
- **Pending register.** Each cycle: `pending <= (pending & ~clr) | edge`.
  - `clr` is the one-hot bit of the source being served; it is non-zero only in INJECT.
  - When set and clear hit the same bit in the same cycle, set wins, so the new request is kept.
- **Eligibility.** `elig = pending & mask & {7{gie}}`. Masked sources keep latching into `pending` but are never selected.
- **Arbiter.** Fixed priority: the lowest set index of `elig` wins. `sel` is that index + 1, in the range 1..7.
- **Configuration writes** take effect on the next edge. They are allowed in any state and do not affect an injection already in progress.
- **State machine** (2-bit, registered):
  - IDLE → INJECT when `elig != 0`. Load `code_r <= sel` on that edge.
  - INJECT → SERVICE unconditionally after one cycle. The served `pending` bit is cleared on that edge; `code_r` returns to 0.
  - SERVICE → IDLE on `reti == 1`. `reti` is ignored in IDLE and INJECT.
- **Output.** `interrupciones = code_r`, which is non-zero only in INJECT. `busy = (state != IDLE)`.
- **No nesting.** Requests arriving in INJECT or SERVICE only latch into `pending` and are arbitrated after the return to IDLE.
- **Reset values:** state = IDLE, `code_r` = 0, `pending` = 0, `irq_q` = 0, `mask` = 7'b1111111, `gie` = 0.
  - Resulting outputs: `interrupciones` = 0, `pending` = 0, `busy` = 0.
- **Reset asserted mid-operation** (INJECT or SERVICE): everything returns to reset values immediately. Pending requests are lost.

## Timing
- A rising edge on `irq[i]` sampled at clock edge k sets `pending[i]` after edge k.
- If eligible, `interrupciones` = i+1 from edge k+1 to edge k+2. This is exactly one cycle, and `pending[i]` is cleared at k+2.
- Minimum interval from a `reti` sample (edge r) to the next injection:
  - state = IDLE after r;
  - the next `interrupciones` is asserted after r+1 if `elig` is non-zero at r+1.
- `gie` or `mask` written at edge w affects arbitration from edge w+1 onward.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Single request.** After reset: `gie_we`=1, `gie_in`=1. Pulse `irq`=7'b0000100 high for 3 cycles.
  - Required: `interrupciones`=3 for exactly one cycle, 2 cycles after the first sampled edge; `busy` stays 1 until `reti`.
- **Priority.** In IDLE with gie=1, raise `irq[5]` and `irq[1]` together.
  - Required: first injection code 2. After `reti`, code 6 the cycle after returning to IDLE.
- **Masking.** `mask_in`=7'b1111110, then raise `irq[0]`.
  - Required: `pending[0]`=1, no injection. Writing mask 7'h7F then yields code 1.
- **No nesting.** While in SERVICE for code 4, raise `irq[0]`.
  - Required: `interrupciones` stays 0 until `reti`, then code 1 follows.
- **Set-beats-clear.** Arrange a new `irq[2]` edge in the INJECT cycle of code 3.
  - Required: `pending[2]` stays 1, and a second code 3 is injected after `reti`.
- **Reset mid-SERVICE.** Assert `reset`=0 asynchronously mid-SERVICE.
  - Required: `interrupciones`=0, `busy`=0, `pending`=0 and gie=0 immediately, without waiting for `clk`.
